// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: opcodes, FSM state
// encoding and the register index type.
package pipe_pkg;

    localparam logic [5:0] OPC_BR0  = 6'b001110;
    localparam logic [5:0] OPC_BR1  = 6'b001111;
    localparam logic [5:0] OPC_HALT = 6'b010001;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        BR_WAIT = 2'd1,
        DRAIN   = 2'd2,
        HALTED  = 2'd3
    } ctrl_state_e;

    typedef logic [4:0] reg_idx_t;

    function automatic logic is_branch_op(input logic [5:0] opc);
        return (opc == OPC_BR0) || (opc == OPC_BR1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_reg_scoreboard.sv
// Countdown scoreboard of in-flight register writes: one counter per
// architectural register, two busy lookup ports and an any-busy summary.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int CW   = 2,
    parameter int IW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_en,
    input  logic [IW-1:0] set_idx,
    input  logic [CW-1:0] set_val,
    input  logic [IW-1:0] rd_a,
    input  logic [IW-1:0] rd_b,
    output logic          busy_a,
    output logic          busy_b,
    output logic          busy_any
);

    logic [CW-1:0] cnt_r [NREG];
    logic          busy_any_s;

    // Counter update: a new issue reloads, otherwise count down to zero; entry 0 stays zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            cnt_r[0] <= '0;
            for (int i = 1; i < NREG; i++) begin
                if (set_en && (set_idx == IW'(i))) begin
                    cnt_r[i] <= set_val;
                end else if (cnt_r[i] != '0) begin
                    cnt_r[i] <= cnt_r[i] - CW'(1'b1);
                end else begin
                    cnt_r[i] <= cnt_r[i];
                end
            end
        end
    end

    // Summary of all live entries, used to decide when a drain is complete.
    always_comb begin
        busy_any_s = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            busy_any_s = busy_any_s | (cnt_r[i] != '0);
        end
    end

    assign busy_a   = (rd_a != '0) && (cnt_r[rd_a] != '0);
    assign busy_b   = (rd_b != '0) && (cnt_r[rd_b] != '0);
    assign busy_any = busy_any_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/halt sequencer beside the ID stage of the 5-stage pipeline.
// Optional macro FWD_EN: EX/MEM forwarding present, shortening writer latency.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int WB_LAT = 3,
    parameter int NREG   = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       id_valid,
    input  logic [5:0] id_opcode,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_uses_rt,
    input  logic [4:0] id_dest,
    input  logic       id_reg_write,
    input  logic       id_is_load,
    input  logic       ex_br_resolved,
    input  logic       ex_br_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       idex_bubble,
    output logic       ifid_flush,
    output logic       pc_redirect,
    output logic       halted,
    output logic       busy_any,
    output logic [1:0] state
);

    localparam int CW = $clog2(WB_LAT + 1);

    localparam logic [1:0] ST_RUN     = RUN;
    localparam logic [1:0] ST_BR_WAIT = BR_WAIT;
    localparam logic [1:0] ST_DRAIN   = DRAIN;
    localparam logic [1:0] ST_HALTED  = HALTED;

    logic [1:0]    state_r;
    logic [1:0]    state_nxt_s;
    logic          busy_rs_s;
    logic          busy_rt_s;
    logic          busy_any_s;
    logic          hazard_s;
    logic          issue_s;
    logic          is_br_s;
    logic          is_halt_s;
    logic          set_en_s;
    logic [CW-1:0] set_val_s;

    assign is_br_s   = is_branch_op(id_opcode);
    assign is_halt_s = (id_opcode == OPC_HALT);
    assign hazard_s  = id_valid && (busy_rs_s || (id_uses_rt && busy_rt_s));
    assign issue_s   = id_valid && (state_r == ST_RUN) && !hazard_s;
    // Branches resolve in EX and never produce a register result here.
    assign set_en_s  = issue_s && id_reg_write && !is_br_s && (id_dest != 5'd0);

`ifdef FWD_EN
    assign set_val_s = id_is_load ? CW'(1'b1) : CW'(1'b0);
`else
    logic unused_is_load_s;
    assign set_val_s        = CW'(WB_LAT);
    assign unused_is_load_s = id_is_load;
`endif

    reg_scoreboard #(
        .NREG (NREG),
        .CW   (CW),
        .IW   (5)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en_s),
        .set_idx  (id_dest),
        .set_val  (set_val_s),
        .rd_a     (id_rs),
        .rd_b     (id_rt),
        .busy_a   (busy_rs_s),
        .busy_b   (busy_rt_s),
        .busy_any (busy_any_s)
    );

    // Next-state decode; a hazard blocks issue so it also blocks branch/halt entry.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN: begin
                if (issue_s && is_br_s) begin
                    state_nxt_s = ST_BR_WAIT;
                end else if (issue_s && is_halt_s) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_BR_WAIT: begin
                if (ex_br_resolved) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_BR_WAIT;
                end
            end
            ST_DRAIN: begin
                if (!busy_any_s) begin
                    state_nxt_s = ST_HALTED;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_HALTED: state_nxt_s = ST_HALTED;
            default:   state_nxt_s = ST_RUN;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Pipeline control outputs, valid in the same cycle as the ID inputs.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        pc_redirect = 1'b0;
        halted      = 1'b0;
        case (state_r)
            ST_RUN: begin
                if (hazard_s) begin
                    pc_stall    = 1'b1;
                    ifid_stall  = 1'b1;
                    idex_bubble = 1'b1;
                end else begin
                    pc_stall    = 1'b0;
                end
            end
            ST_BR_WAIT: begin
                pc_stall    = 1'b1;
                ifid_flush  = 1'b1;
                pc_redirect = ex_br_resolved && ex_br_taken;
            end
            ST_DRAIN: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
            end
            ST_HALTED: begin
                pc_stall   = 1'b1;
                ifid_flush = 1'b1;
                halted     = 1'b1;
            end
            default: begin
                pc_stall = 1'b0;
            end
        endcase
    end

    assign busy_any = busy_any_s;
    assign state    = state_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus random
// traffic compared against a ready-cycle reference model.
module tb_pipe_hazard_ctrl;
    import pipe_pkg::*;

    localparam int WB_LAT = 3;
`ifdef FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam int M_RUN = 0, M_BRW = 1, M_DRAIN = 2, M_HALTED = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid = 1'b0;
    logic [5:0] id_opcode = 6'd0;
    logic [4:0] id_rs = 5'd0, id_rt = 5'd0, id_dest = 5'd0;
    logic       id_uses_rt = 1'b0, id_reg_write = 1'b0, id_is_load = 1'b0;
    logic       ex_br_resolved = 1'b0, ex_br_taken = 1'b0;
    logic       pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    int ready_at[32];
    int mstate = M_RUN;
    int cyc    = 0;
    bit m_hz, m_issue;
    logic e_pc_stall, e_ifid_stall, e_bubble, e_flush, e_redirect, e_halted, e_busy_any;
    logic [1:0] e_state;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_opcode      (id_opcode),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_uses_rt     (id_uses_rt),
        .id_dest        (id_dest),
        .id_reg_write   (id_reg_write),
        .id_is_load     (id_is_load),
        .ex_br_resolved (ex_br_resolved),
        .ex_br_taken    (ex_br_taken),
        .pc_stall       (pc_stall),
        .ifid_stall     (ifid_stall),
        .idex_bubble    (idex_bubble),
        .ifid_flush     (ifid_flush),
        .pc_redirect    (pc_redirect),
        .halted         (halted),
        .busy_any       (busy_any),
        .state          (state)
    );

    // Result of a writer becomes readable lat+1 cycles after its issue cycle.
    function automatic int lat_for(input logic ld);
        if (FWD) return ld ? 1 : 0;
        return WB_LAT;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) ready_at[r] = 0;
        mstate = M_RUN;
    endtask

    task automatic model_eval();
        bit brs, brt;
        brs = (id_rs != 5'd0) && (ready_at[id_rs] > cyc);
        brt = id_uses_rt && (id_rt != 5'd0) && (ready_at[id_rt] > cyc);
        m_hz = id_valid && (brs || brt);
        e_busy_any = 1'b0;
        for (int r = 1; r < 32; r++) if (ready_at[r] > cyc) e_busy_any = 1'b1;
        {e_pc_stall, e_ifid_stall, e_bubble, e_flush, e_redirect, e_halted} = 6'b0;
        e_state = 2'(mstate);
        m_issue = 1'b0;
        case (mstate)
            M_RUN: begin
                if (m_hz) {e_pc_stall, e_ifid_stall, e_bubble} = 3'b111;
                else m_issue = id_valid;
            end
            M_BRW: begin
                e_pc_stall = 1'b1; e_flush = 1'b1;
                e_redirect = ex_br_resolved && ex_br_taken;
            end
            M_DRAIN: begin
                e_pc_stall = 1'b1; e_flush = 1'b1;
            end
            default: begin
                e_pc_stall = 1'b1; e_flush = 1'b1; e_halted = 1'b1;
            end
        endcase
    endtask

    task automatic model_commit();
        int nxt;
        bit br;
        nxt = mstate;
        br = (id_opcode == OPC_BR0) || (id_opcode == OPC_BR1);
        if (m_issue && id_reg_write && id_dest != 5'd0 && !br)
            ready_at[id_dest] = cyc + lat_for(id_is_load) + 1;
        case (mstate)
            M_RUN:   if (m_issue && br) nxt = M_BRW;
                     else if (m_issue && id_opcode == OPC_HALT) nxt = M_DRAIN;
            M_BRW:   if (ex_br_resolved) nxt = M_RUN;
            M_DRAIN: if (!e_busy_any) nxt = M_HALTED;
            default: nxt = mstate;
        endcase
        mstate = nxt;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [5:0] opc, input logic [4:0] rs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic ld, input logic brr, input logic brt);
        @(negedge clk);
        id_valid = v; id_opcode = opc; id_rs = rs; id_rt = rt; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_is_load = ld;
        ex_br_resolved = brr; ex_br_taken = brt;
        #1;
        model_eval();
    endtask

    task automatic advance();
        @(posedge clk);
        model_commit();
    endtask

    task automatic idle_inputs();
        id_valid = 1'b0; id_opcode = 6'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
        id_dest = 5'd0; id_reg_write = 1'b0; id_is_load = 1'b0;
        ex_br_resolved = 1'b0; ex_br_taken = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        #1 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b exp=0000000",
                     {pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any});
        end
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL reset_state got=%0d exp=0", state);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_dependency(input logic ld);
        int stalls, bubbles, exp_st;
        bit done;
        stalls = 0; bubbles = 0; done = 1'b0;
        exp_st = FWD ? (ld ? 1 : 0) : WB_LAT;
        do_reset();
        drive(1'b1, 6'd1, 5'd0, 5'd0, 1'b0, 5'd5, 1'b1, ld, 1'b0, 1'b0);
        n_checks++;
        if (pc_stall !== 1'b0) begin
            n_fail++; $display("FAIL dep_producer_issue got=%b exp=0", pc_stall);
        end
        advance();
        for (int k = 0; k < 10 && !done; k++) begin
            drive(1'b1, 6'd2, 5'd5, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
            if (pc_stall === 1'b1) stalls++;
            else done = 1'b1;
            if (idex_bubble === 1'b1) bubbles++;
            advance();
        end
        n_checks++;
        if (!done) begin
            n_fail++; $display("FAIL dep_timeout load=%0d got=no_issue exp=issue", ld);
        end
        n_checks++;
        if (stalls != exp_st) begin
            n_fail++; $display("FAIL dep_stalls load=%0d got=%0d exp=%0d", ld, stalls, exp_st);
        end
        n_checks++;
        if (bubbles != exp_st) begin
            n_fail++; $display("FAIL dep_bubbles load=%0d got=%0d exp=%0d", ld, bubbles, exp_st);
        end
    endtask

    task automatic test_r0();
        do_reset();
        drive(1'b1, 6'd1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, 6'd2, 5'd0, 5'd0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pc_stall !== 1'b0 || idex_bubble !== 1'b0) begin
            n_fail++; $display("FAIL r0_stall got=%b%b exp=00", pc_stall, idex_bubble);
        end
        n_checks++;
        if (busy_any !== 1'b0) begin
            n_fail++; $display("FAIL r0_busy got=%b exp=0", busy_any);
        end
        advance();
    endtask

    task automatic test_branch();
        int flushes;
        flushes = 0;
        do_reset();
        drive(1'b1, OPC_BR0, 5'd0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        n_checks++;
        if (pc_stall !== 1'b0 || state !== 2'd0) begin
            n_fail++; $display("FAIL br_issue got=stall%b st%0d exp=stall0 st0", pc_stall, state);
        end
        advance();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ifid_flush === 1'b1) flushes++;
        n_checks++;
        if (state !== 2'd1 || pc_stall !== 1'b1 || pc_redirect !== 1'b0 || busy_any !== 1'b0) begin
            n_fail++;
            $display("FAIL br_wait got=st%0d stall%b redir%b busy%b exp=st1 stall1 redir0 busy0",
                     state, pc_stall, pc_redirect, busy_any);
        end
        advance();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        if (ifid_flush === 1'b1) flushes++;
        n_checks++;
        if (pc_redirect !== 1'b1) begin
            n_fail++; $display("FAIL br_redirect got=%b exp=1", pc_redirect);
        end
        advance();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        if (ifid_flush === 1'b1) flushes++;
        n_checks++;
        if (state !== 2'd0 || pc_redirect !== 1'b0) begin
            n_fail++; $display("FAIL br_return got=st%0d redir%b exp=st0 redir0", state, pc_redirect);
        end
        n_checks++;
        if (flushes != 2) begin
            n_fail++; $display("FAIL br_flush_cycles got=%0d exp=2", flushes);
        end
        advance();
    endtask

    task automatic test_halt();
        int drains, exp_dr;
        bit done;
        drains = 0; done = 1'b0;
        exp_dr = FWD ? 1 : 2;
        do_reset();
        drive(1'b1, 6'd3, 5'd0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
        advance();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, OPC_HALT, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        for (int k = 0; k < 10 && !done; k++) begin
            drive(1'b1, 6'd1, 5'd0, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
            if (state === 2'd2) drains++;
            else done = 1'b1;
            if (!done) advance();
        end
        n_checks++;
        if (drains != exp_dr) begin
            n_fail++; $display("FAIL halt_drain_cycles got=%0d exp=%0d", drains, exp_dr);
        end
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (state !== 2'd3 || halted !== 1'b1 || pc_stall !== 1'b1 || ifid_flush !== 1'b1 || busy_any !== 1'b0) begin
                n_fail++;
                $display("FAIL halted_hold k=%0d got=st%0d h%b s%b f%b b%b exp=st3 h1 s1 f1 b0",
                         k, state, halted, pc_stall, ifid_flush, busy_any);
            end
            advance();
            drive(1'b1, 6'd1, 5'd0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
        end
        advance();
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(1'b1, 6'd1, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b1, OPC_BR1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        advance();
        drive(1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        n_checks++;
        if (state !== 2'd1 || pc_redirect !== 1'b1) begin
            n_fail++; $display("FAIL ares_pre got=st%0d redir%b exp=st1 redir1", state, pc_redirect);
        end
        #2 rst = 1'b0;
        #1;
        model_reset();
        n_checks++;
        if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any} !== 7'b0) begin
            n_fail++;
            $display("FAIL ares_outputs got=%b exp=0000000",
                     {pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any});
        end
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++; $display("FAIL ares_state got=%0d exp=0", state);
        end
        idle_inputs();
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        logic [8:0] got, exp;
        logic [5:0] opc;
        int sel;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if (mstate == M_HALTED && $urandom_range(0, 3) == 0) do_reset();
            sel = $urandom_range(0, 63);
            if (sel < 4) opc = OPC_BR0;
            else if (sel < 8) opc = OPC_BR1;
            else if (sel == 8) opc = OPC_HALT;
            else opc = 6'($urandom_range(0, 13));
            drive(1'($urandom_range(0, 9) < 8), opc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
            got = {pc_stall, ifid_stall, idex_bubble, ifid_flush, pc_redirect, halted, busy_any, state};
            exp = {e_pc_stall, e_ifid_stall, e_bubble, e_flush, e_redirect, e_halted, e_busy_any, e_state};
            n_checks++;
            if (got !== exp) begin
                n_fail++; $display("FAIL rnd_outputs iter=%0d got=%b exp=%b", k, got, exp);
            end
            advance();
        end
    endtask

    initial begin
        test_reset();
        test_dependency(1'b0);
        test_dependency(1'b1);
        test_r0();
        test_branch();
        test_halt();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush/halt sequencer for the 5-stage integer pipeline. It sits beside the ID stage and tracks in-flight register writes in a countdown scoreboard. It decides when the PC and IF/ID register stall, when a bubble goes into ID/EX, and when fetch is frozen for branch resolution. It also drains the pipeline on HALT and then reports the halted condition.

Parameters:
WB_LAT, 3, cycles from ID issue until the written value is readable from the register file (issue cycle excluded)
NREG, 32, architectural register count; register 0 is hardwired zero
OPC_BR0, 6'b001110, first branch/jump opcode
OPC_BR1, 6'b001111, second branch/jump opcode
OPC_HALT, 6'b010001, halt opcode

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  6  instr[31:26] of the ID instruction
id_rs  in  5  source register rs
id_rt  in  5  source register rt
id_uses_rt  in  1  rt is a source; when 0, rt is a destination only
id_dest  in  5  destination register
id_reg_write  in  1  ID instruction writes id_dest
id_is_load  in  1  ID instruction is a load
ex_br_resolved  in  1  EX has resolved the outstanding branch (1-cycle pulse)
ex_br_taken  in  1  qualifies ex_br_resolved
pc_stall  out  1  hold the PC
ifid_stall  out  1  hold the IF/ID register
idex_bubble  out  1  load a NOP into ID/EX
ifid_flush  out  1  replace the IF/ID content with a NOP
pc_redirect  out  1  load the PC from the EX branch target (1 cycle)
halted  out  1  pipeline drained after HALT
busy_any  out  1  any scoreboard entry is non-zero
state  out  2  FSM state for debug

Behaviour:
- Reset (rst=0, asynchronous): state=RUN. All scoreboard counters=0. All outputs=0.
- Scoreboard: NREG counters of clog2(WB_LAT+1) bits each.
  - Each counter decrements every cycle while non-zero.
  - Issue of a writer with id_dest!=0 loads that counter with WB_LAT. A load on the same cycle as a decrement wins.
  - Entry 0 is never set.
- Source hazard: id_valid and (busy(id_rs) or (id_uses_rt and busy(id_rt))), where busy(r) = cnt[r]!=0. Source register 0 is never busy.
- Issue = id_valid, state==RUN, and no hazard.
- FSM states: RUN=0, BR_WAIT=1, DRAIN=2, HALTED=3.
- RUN:
  - On a hazard: pc_stall=ifid_stall=idex_bubble=1. Nothing issues. A hazard takes priority over branch/halt decode.
  - Issue of opcode BR0/BR1: go to BR_WAIT. The branch itself passes to EX and sets no scoreboard entry.
  - Issue of HALT: go to DRAIN.
  - An ex_br_resolved pulse in RUN is ignored.
- BR_WAIT:
  - pc_stall=1 and ifid_flush=1 every cycle.
  - On ex_br_resolved, drive pc_redirect=ex_br_taken for that same cycle and return to RUN the next cycle. Fetch resumes from PC+4 or from the target.
- DRAIN:
  - pc_stall=1 and ifid_flush=1.
  - When busy_any==0, go to HALTED. If already empty on entry, the transition happens the next cycle.
- HALTED:
  - halted=1, pc_stall=1, ifid_flush=1. Absorbing; only reset exits.
- Reset asserted mid-BR_WAIT or mid-DRAIN clears the state and scoreboard immediately.
- All outputs except pc_redirect are combinational from the registered state, the scoreboard and the ID inputs. They are valid in the same cycle.

Optional Feature:
FWD_EN.
- Defined: the EX/MEM forwarding network is present.
  - A non-load writer loads its counter with 0 and creates no stall.
  - A load loads 1, giving exactly one bubble for a dependent instruction issued immediately after it.
- Undefined: every writer loads WB_LAT. A dependent instruction issued immediately after its producer stalls WB_LAT cycles.

Decomposition:
- Shared package pipe_pkg holds:
  - the opcode constants OPC_BR0, OPC_BR1, OPC_HALT;
  - the enum ctrl_state_e {RUN, BR_WAIT, DRAIN, HALTED};
  - the typedef reg_idx_t (logic [4:0]).
- One natural sub-module, reg_scoreboard: the counters, set/decrement logic, the busy lookup on two read ports, and busy_any.

Test Plan:
- Dependency, FWD_EN undefined: write r5, then read r5 in the next instruction -> pc_stall/idex_bubble high 3 cycles, then the dependent instruction issues.
- Same sequence with FWD_EN defined: non-load producer -> 0 stall cycles; producer is a load -> exactly 1 bubble.
- r0 handling: write r0, then read r0 -> no stall; cnt[0] stays 0.
- Branch: BR0 issued, ex_br_resolved arrives 2 cycles later with taken=1 -> ifid_flush high 2 cycles, pc_redirect high 1 cycle, state returns to RUN.
- Halt: HALT issued with r7 counting 2 -> DRAIN for 2 cycles, then HALTED with halted=1; further id_valid inputs are ignored.
- Async reset asserted while in BR_WAIT -> all outputs 0 and state=RUN immediately, without waiting for a clock edge.
